// File: rtl/pb_key_encoder.sv
// pb_key_encoder: pushbutton conditioning for the game logic.
// Per button: 2-flop sync, 3-sample debounce on a slow tick, press-edge
// detect into a pending mask, then lowest-index-first into a keycode FIFO
// drained by a valid/ready handshake.
// Optional feature: define PB_AUTOREPEAT_EN to add a single auto-repeat
// tracker on the lowest-index held button.
module pb_key_encoder #(
  parameter int NBTN            = 21,
  parameter int CW              = $clog2(NBTN),
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input  logic            hwclk,
  input  logic            reset,
  input  logic [NBTN-1:0] pb,
  output logic [NBTN-1:0] pb_level,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            overflow
);

  localparam int TCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [NBTN-1:0] s1, s2;       // synchronizer stages
  logic [NBTN-1:0] h0, h1;       // last two samples; with s2 they form the 3-sample window
  logic [NBTN-1:0] lvl_next, rise, rep_set, evt;
  logic [NBTN-1:0] pending, pmask, clr;
  logic [TCW-1:0]  cnt;
  logic            tick;
  logic [CW-1:0]   psel;
  logic [CW-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]     wptr, rptr, wptr_n, rptr_n;
  logic            full, empty, pop, push;

  assign tick = (cnt == TCW'(DEBOUNCE_CYCLES - 1));

  // Level follows the window only when all three samples agree
  always_comb begin
    lvl_next = pb_level;
    if (tick) lvl_next = (h1 & h0 & s2) | (pb_level & (h1 | h0 | s2));
  end

  assign rise = lvl_next & ~pb_level;
  assign evt  = rise | rep_set;

  // Lowest pending index wins the single push slot
  always_comb begin
    psel = '0;
    for (int i = NBTN - 1; i >= 0; i--)
      if (pending[i]) psel = CW'(i);
  end

  assign pmask  = pending & (~pending + 1'b1);
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = key_valid & key_ready;
  assign push   = (|pending) & (~full | pop);
  assign clr    = push ? pmask : '0;
  assign wptr_n = wptr + (AW+1)'(push);
  assign rptr_n = rptr + (AW+1)'(pop);

  // Sync, debounce, tick counter, pending mask and FIFO pointers
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      h0        <= '0;
      h1        <= '0;
      cnt       <= '0;
      pb_level  <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      s1       <= pb;
      s2       <= s1;
      cnt      <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        h1 <= h0;
        h0 <= s2;
      end
      pb_level <= lvl_next;
      // A press landing on a still-set pending bit is merged and reported lost
      pending  <= (pending & ~clr) | evt;
      overflow <= |(evt & pending & ~clr);
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      key_valid <= (wptr_n != rptr_n);
      // Head of the next state; a push into an empty queue becomes the head
      key_code <= (push && (wptr == rptr_n)) ? psel : mem[rptr_n[AW-1:0]];
    end
  end

  // Keycode storage, written at the tail
  always_ff @(posedge hwclk) begin
    if (push) mem[wptr[AW-1:0]] <= psel;
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);

  logic            rep_act, rep_arm, trk_any, rep_hit, rep_fire;
  logic [CW-1:0]   rep_idx, trk_idx;
  logic [RCW-1:0]  rep_cnt, rep_lim;

  // Tracker follows the lowest-index held button
  always_comb begin
    trk_any = |pb_level;
    trk_idx = '0;
    for (int i = NBTN - 1; i >= 0; i--)
      if (pb_level[i]) trk_idx = CW'(i);
  end

  assign rep_lim  = rep_arm ? RCW'(REPEAT_RATE) : RCW'(REPEAT_DELAY);
  assign rep_hit  = (RCW'(rep_cnt + 1'b1) == rep_lim);
  // Only fire while the button is still debounced-held after this tick
  assign rep_fire = tick & rep_act & trk_any & (trk_idx == rep_idx) & rep_hit & lvl_next[rep_idx];
  assign rep_set  = rep_fire ? (NBTN'(1) << rep_idx) : '0;

  // Delay then periodic repeat; a new tracked index restarts the delay
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      rep_act <= 1'b0;
      rep_arm <= 1'b0;
      rep_idx <= '0;
      rep_cnt <= '0;
    end else if (tick) begin
      if (!trk_any) begin
        rep_act <= 1'b0;
      end else if (!rep_act || trk_idx != rep_idx) begin
        rep_act <= 1'b1;
        rep_arm <= 1'b0;
        rep_idx <= trk_idx;
        rep_cnt <= RCW'(1);
      end else if (rep_hit) begin
        rep_arm <= 1'b1;
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_rep;
  assign rep_set    = '0;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

endmodule

// File: tb/tb_pb_key_encoder.sv
// Directed bench for pb_key_encoder with an 8-cycle debounce tick.
module tb_pb_key_encoder;
  localparam int NBTN = 21;
  localparam int CW   = 5;

  logic            hwclk = 1'b0;
  logic            reset;
  logic [NBTN-1:0] pb;
  logic [NBTN-1:0] pb_level;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_ready;
  logic            overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  logic [CW-1:0] q[$];
  int qt[$];

  pb_key_encoder #(
    .NBTN(NBTN), .CW(CW), .DEBOUNCE_CYCLES(8), .FIFO_DEPTH(4),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .hwclk(hwclk), .reset(reset), .pb(pb), .pb_level(pb_level),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .overflow(overflow)
  );

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc++;

  // Record accepted codes and overflow pulses away from the active edge
  always @(negedge hwclk) begin
    if (!reset && key_valid && key_ready) begin
      q.push_back(key_code);
      qt.push_back(cyc);
    end
    if (!reset && overflow) ovf_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; pb = '1; key_ready = 1'b0;
    step(3);
    checks++; if (pb_level !== '0) begin errors++; $display("FAIL rst_level: got %h want 0", pb_level); end
    checks++; if (key_code !== '0) begin errors++; $display("FAIL rst_code: got %0d want 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", key_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    reset = 1'b0; key_ready = 1'b1;
    step(30);
    checks++; if (pb_level !== {NBTN{1'b1}}) begin errors++; $display("FAIL rst_allhigh: got %h want 1fffff", pb_level); end
    step(30);
    checks++;
    if (q.size() != NBTN) begin
      errors++; $display("FAIL rst_count: got %0d want %0d", q.size(), NBTN);
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        checks++;
        if (q[i] !== CW'(i)) begin errors++; $display("FAIL rst_order[%0d]: got %0d want %0d", i, q[i], i); end
      end
    end
    pb = '0;
    step(40);
    checks++; if (q.size() != NBTN) begin errors++; $display("FAIL rst_release: got %0d codes want %0d", q.size(), NBTN); end
    checks++; if (pb_level !== '0) begin errors++; $display("FAIL rst_level_low: got %h want 0", pb_level); end
  endtask

  task automatic test_bounce;
    q.delete(); qt.delete(); ovf_cnt = 0;
    pb[3] = 1'b1; step(8);
    pb[3] = 1'b0; step(8);
    pb[3] = 1'b1; step(40);
    checks++;
    if (q.size() != 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", q.size()); end
    else begin
      checks++; if (q[0] !== 5'd3) begin errors++; $display("FAIL bounce_code: got %0d want 3", q[0]); end
    end
    pb[3] = 1'b0; step(40);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL bounce_release: got %0d codes want 1", q.size()); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL bounce_ovf: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_ordering;
    q.delete(); qt.delete();
    pb[5] = 1'b1; pb[2] = 1'b1;
    step(40);
    checks++;
    if (q.size() != 2) begin errors++; $display("FAIL order_count: got %0d want 2", q.size()); end
    else begin
      checks++; if (q[0] !== 5'd2) begin errors++; $display("FAIL order_first: got %0d want 2", q[0]); end
      checks++; if (q[1] !== 5'd5) begin errors++; $display("FAIL order_second: got %0d want 5", q[1]); end
      checks++; if (qt[1] - qt[0] != 1) begin errors++; $display("FAIL order_gap: got %0d want 1", qt[1] - qt[0]); end
    end
    pb = '0; step(40);
  endtask

  task automatic test_backpressure;
    q.delete(); qt.delete(); ovf_cnt = 0;
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pb[i] = 1'b1;
      step(40);
    end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", key_valid); end
    checks++; if (key_code !== 5'd0) begin errors++; $display("FAIL bp_head: got %0d want 0", key_code); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL bp_ovf_pre: got %0d want 0", ovf_cnt); end
    pb[4] = 1'b0; step(40);
    pb[4] = 1'b1; step(40);
    checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL bp_ovf: got %0d want 1", ovf_cnt); end
    key_ready = 1'b1; step(20);
    checks++;
    if (q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q[i] !== CW'(i)) begin errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, q[i], i); end
      end
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", key_valid); end
    pb = '0; step(40);
    checks++; if (q.size() != 5) begin errors++; $display("FAIL bp_release: got %0d codes want 5", q.size()); end
  endtask

  task automatic test_async_reset;
    q.delete(); qt.delete();
    key_ready = 1'b0;
    pb = 21'h1f;
    step(40);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", key_valid); end
    #3 reset = 1'b1;
    #1;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", key_valid); end
    checks++; if (pb_level !== '0) begin errors++; $display("FAIL ar_level: got %h want 0", pb_level); end
    checks++; if (key_code !== '0) begin errors++; $display("FAIL ar_code: got %0d want 0", key_code); end
    step(3);
    q.delete(); qt.delete();
    key_ready = 1'b1; reset = 1'b0;
    step(50);
    checks++;
    if (q.size() != 5) begin errors++; $display("FAIL ar_count: got %0d want 5", q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q[i] !== CW'(i)) begin errors++; $display("FAIL ar_order[%0d]: got %0d want %0d", i, q[i], i); end
      end
    end
    pb = '0; step(40);
  endtask

  task automatic test_autorepeat;
    int exp_n;
    bit bad;
`ifdef PB_AUTOREPEAT_EN
    exp_n = 9;
`else
    exp_n = 1;
`endif
    reset = 1'b1; pb = '0; step(1);
    q.delete(); qt.delete(); ovf_cnt = 0;
    key_ready = 1'b1; reset = 1'b0; pb[7] = 1'b1;
    step(160);
    pb = '0;
    step(40);
    checks++; if (q.size() != exp_n) begin errors++; $display("FAIL rep_count: got %0d want %0d", q.size(), exp_n); end
    bad = 1'b0;
    foreach (q[i]) if (q[i] !== 5'd7) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL rep_code: got a code other than 7 want only 7"); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL rep_ovf: got %0d want 0", ovf_cnt); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_ordering;
    test_backpressure;
    test_async_reset;
    test_autorepeat;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
